// File: rtl/gcd_requester.sv
// rtl/gcd_requester.sv - initiator side of the GCD engine go/done handshake
//
// Accepts operand pairs on a valid/ready input stream, drives the GCD engine
// through go/done, and returns each result on a valid/ready output stream.
// Pairs with a zero operand are answered locally because the subtractive
// engine never terminates when exactly one operand is zero.
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   in_valid/in_ready/in_a/in_b   operand pair input stream
//   gcd_go/gcd_x/gcd_y            request to the GCD engine (registered)
//   gcd_done/gcd_result           engine completion and result
//   out_valid/out_ready           result output stream handshake
//   out_gcd/out_err/out_cycles    result, both-zero flag, go-high cycle count
//   busy                          high whenever not idle
//   jobs_done                     wrapping count of results taken downstream

module gcd_requester #(
  parameter int WIDTH = 8,
  parameter int CYC_W = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             gcd_go,
  output logic [WIDTH-1:0] gcd_x,
  output logic [WIDTH-1:0] gcd_y,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic [CYC_W-1:0] out_cycles,
  output logic             busy,
  output logic [CNT_W-1:0] jobs_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_RESP    = 3'd3;

  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  logic [2:0]       state_q, state_d;
  logic             go_q, go_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] ogcd_q, ogcd_d;
  logic             oerr_q, oerr_d;
  logic [CYC_W-1:0] ocyc_q, ocyc_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] jobs_q, jobs_d;
  logic [CYC_W-1:0] cyc_inc;

  // Saturating increment; the counter value during an ISSUE cycle already
  // includes that cycle, so a done in the first ISSUE cycle reports 1.
  assign cyc_inc = (cnt_q == CYC_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    go_d    = go_q;
    x_d     = x_q;
    y_d     = y_q;
    ov_d    = ov_q;
    ogcd_d  = ogcd_q;
    oerr_d  = oerr_q;
    ocyc_d  = ocyc_q;
    cnt_d   = cnt_q;
    jobs_d  = jobs_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d = in_a;
          y_d = in_b;
          if ((in_a == '0) || (in_b == '0)) begin
            // Bypass: the engine would spin forever on a single zero.
            ogcd_d  = in_a | in_b;
            oerr_d  = (in_a == '0) && (in_b == '0);
            ocyc_d  = '0;
            ov_d    = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = '0;
            go_d    = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        cnt_d = cyc_inc;
        if (gcd_done) begin
          ogcd_d  = gcd_result;
          ocyc_d  = cyc_inc;
          oerr_d  = 1'b0;
          go_d    = 1'b0;
          state_d = S_RELEASE;
        end
      end

      S_RELEASE: begin
        // Wait for done to fall so it cannot complete the next job early.
        go_d = 1'b0;
        if (!gcd_done) begin
          ov_d    = 1'b1;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          jobs_d  = jobs_q + 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        go_d    = 1'b0;
        ov_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      go_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ov_q    <= 1'b0;
      ogcd_q  <= '0;
      oerr_q  <= 1'b0;
      ocyc_q  <= '0;
      cnt_q   <= '0;
      jobs_q  <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ov_q    <= ov_d;
      ogcd_q  <= ogcd_d;
      oerr_q  <= oerr_d;
      ocyc_q  <= ocyc_d;
      cnt_q   <= cnt_d;
      jobs_q  <= jobs_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign gcd_go     = go_q;
  assign gcd_x      = x_q;
  assign gcd_y      = y_q;
  assign out_valid  = ov_q;
  assign out_gcd    = ogcd_q;
  assign out_err    = oerr_q;
  assign out_cycles = ocyc_q;
  assign jobs_done  = jobs_q;

endmodule

// File: doc/gcd_requester.md
Name: gcd_requester

Overview:
Initiator side of the GCD engine's go/done handshake. Accepts operand pairs on a valid/ready input stream and presents them to the GCD engine. Raises go, captures the result when done is seen, then drops go and waits for done to clear. Returns each result on a valid/ready output stream with a status flag and a latency count. Handles zero operands locally, because the subtractive engine never terminates when exactly one operand is zero.

Parameters:
WIDTH, 8, operand/result width in bits
CYC_W, 12, width of the per-job latency counter (saturating)
CNT_W, 16, width of the completed-job counter (wrapping)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair available
in_ready  output  1  requester can accept a pair
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
gcd_go  output  1  go to GCD engine
gcd_x  output  WIDTH  operand A to engine, registered
gcd_y  output  WIDTH  operand B to engine, registered
gcd_done  input  1  engine done
gcd_result  input  WIDTH  engine result, valid while gcd_done=1
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_gcd  output  WIDTH  GCD result
out_err  output  1  1 = both operands were zero (result 0 is undefined)
out_cycles  output  CYC_W  cycles gcd_go was high for this job; 0 for bypassed jobs
busy  output  1  high in any state other than IDLE
jobs_done  output  CNT_W  count of results accepted downstream

Behaviour:
- Reset (rst_n=0, async): state=IDLE. gcd_go=0, out_valid=0, gcd_x=gcd_y=0, out_gcd=0, out_err=0, out_cycles=0, jobs_done=0, busy=0. in_ready is 1 after reset (IDLE).
- All outputs are registered except in_ready and busy, which decode from state.
- in_ready=1 only in IDLE. A pair is accepted on a rising edge with in_valid&&in_ready.
- States:
  - IDLE: on accept, latch in_a→gcd_x and in_b→gcd_y.
    - If in_a==0 or in_b==0 (bypass): out_gcd=in_a|in_b, out_err=(in_a==0&&in_b==0), out_cycles=0, out_valid=1, go to RESP. gcd_go never pulses.
    - Otherwise: clear the cycle counter, gcd_go=1, go to ISSUE. gcd_go is high starting the cycle after accept.
  - ISSUE: gcd_go held 1, gcd_x/gcd_y held stable. The cycle counter increments each cycle and saturates at 2^CYC_W-1.
    - On the first cycle gcd_done=1: capture gcd_result→out_gcd, counter→out_cycles, out_err=0. Then set gcd_go=0 and go to RELEASE.
  - RELEASE: gcd_go=0. Stay until gcd_done=0, then set out_valid=1 and go to RESP. This prevents a stale done from being taken as completion of the next job.
  - RESP: out_valid=1 with out_gcd/out_err/out_cycles held stable until out_ready.
    - On out_valid&&out_ready: out_valid=0, jobs_done+=1 (wraps at 2^CNT_W), go to IDLE.
    - No new input is accepted in the same cycle; the next accept is possible one cycle later.
- Only one job is in flight; no input buffering.
- If gcd_done=1 is seen in IDLE or RESP, it is ignored.
- Invalid state encoding recovers to IDLE with gcd_go=0.
- Reset mid-operation: gcd_go and out_valid drop asynchronously and any in-flight result is discarded. The engine is reset on its own reset domain.

Test Plan:
1. Engine model, in_a=12, in_b=8 → gcd_go=1 the cycle after accept. gcd_x=12, gcd_y=8 stable until done. Then out_gcd=4, out_err=0, out_cycles equal to the model's go-high cycles, jobs_done=1.
2. Bypass cases, checked separately:
   - in_a=0, in_b=9 → gcd_go stays 0; out_valid=1 one cycle after accept with out_gcd=9, out_err=0, out_cycles=0.
   - in_a=0, in_b=0 → out_gcd=0, out_err=1.
3. Output backpressure: out_ready=0 for 5 cycles after out_valid → out_gcd/out_err/out_cycles stable and in_ready=0 throughout; jobs_done increments exactly once on the accepting edge.
4. Back-to-back jobs (21,14) then (9,6), with the model holding gcd_done high 1 cycle after go falls → second gcd_go is not raised until gcd_done=0; results are 7 then 3.
5. rst_n pulsed low mid-ISSUE → gcd_go=0, out_valid=0, busy=0 with no clock edge; jobs_done=0. The next job after release completes correctly.
6. CYC_W=4, model delays gcd_done 20 cycles after go → out_cycles=15 (saturated); out_gcd correct.
